// File: rtl/arp_rx.sv
// -----------------------------------------------------------------------------
// arp_rx -- ARP packet receiver on a 64-bit AXI-Stream input.
//
// Parses an ARP payload presented as 64-bit beats with the first byte in
// [63:56]. It validates the fixed header fields and checks that the target IP
// matches the local IP. For every accepted packet it reports the sender's
// MAC/IP. An accepted request (oper 1) also pulses o_arp_reply so that a
// transmitter can answer it.
//
// Optional feature: define ARP_RX_STATS_EN to add the packet counters
// o_rx_ok_cnt / o_rx_drop_cnt. Both counters are 16 bits wide and wrap.
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst                 asynchronous reset, active low
//   i_dymanic_src_ip      new local IP, loaded when i_src_ip_valid is high
//   i_src_ip_valid        load strobe for the local IP
//   s_axis_arp_*          ARP payload stream; user = {len, src MAC, ethertype}
//   s_axis_arp_ready      always 1 out of reset
//   o_recv_target_mac/ip  sender MAC/IP of the last accepted packet
//   o_recv_target_valid   one-cycle pulse when the fields above update
//   o_arp_reply           one-cycle pulse for an accepted request to us
//   o_local_mac           P_SRC_MAC_ADDR
//   o_rx_ok_cnt           accepted packets   (ARP_RX_STATS_EN only)
//   o_rx_drop_cnt         dropped packets    (ARP_RX_STATS_EN only)
// -----------------------------------------------------------------------------
module arp_rx #(
   parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
   parameter logic [47:0] P_SRC_MAC_ADDR = 48'h01_02_03_04_05_06
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_dymanic_src_ip,
   input  logic        i_src_ip_valid,
   input  logic [63:0] s_axis_arp_data,
   input  logic [79:0] s_axis_arp_user,
   input  logic [7:0]  s_axis_arp_keep,
   input  logic        s_axis_arp_last,
   input  logic        s_axis_arp_valid,
   output logic        s_axis_arp_ready,
   output logic [47:0] o_recv_target_mac,
   output logic [31:0] o_recv_target_ip,
   output logic        o_recv_target_valid,
   output logic        o_arp_reply,
`ifdef ARP_RX_STATS_EN
   output logic [15:0] o_rx_ok_cnt,
   output logic [15:0] o_rx_drop_cnt,
`endif
   output logic [47:0] o_local_mac
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t      state, state_nxt;
   logic [2:0]  beat_cnt;
   logic [31:0] local_ip;
   logic [47:0] sh_mac;
   logic [31:0] sh_ip;
   logic        is_request;
   logic        hs;
   logic        b0_ok;
   logic        tip_ok;
   logic        accept;
   logic        drop_done;
   logic        unused_bits;

   assign o_local_mac = P_SRC_MAC_ADDR;
   assign hs          = s_axis_arp_valid & s_axis_arp_ready;

   // Packet length and keep carry nothing the parser needs.
   assign unused_bits = ^{s_axis_arp_keep, s_axis_arp_user[79:16]};

   assign b0_ok = (s_axis_arp_user[15:0]   == 16'h0806) &&
                  (s_axis_arp_data[63:48] == 16'h0001) &&
                  (s_axis_arp_data[47:32] == 16'h0800) &&
                  (s_axis_arp_data[31:24] == 8'd6)     &&
                  (s_axis_arp_data[23:16] == 8'd4)     &&
                  ((s_axis_arp_data[15:0] == 16'd1) || (s_axis_arp_data[15:0] == 16'd2));

   // Compared against the register's current value, so a load in the same
   // cycle as b3 only affects later packets.
   assign tip_ok = (s_axis_arp_data[63:32] == local_ip);

   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      drop_done = 1'b0;
      case (state)
         IDLE: if (hs) begin
            if (s_axis_arp_last) drop_done = 1'b1;
            else                 state_nxt = b0_ok ? RECV : DROP;
         end
         RECV: if (hs) begin
            if (s_axis_arp_last) begin
               // A packet cut short before b3 never carried a target IP.
               if ((beat_cnt >= 3'd3) && ((beat_cnt != 3'd3) || tip_ok)) accept = 1'b1;
               else                                                      drop_done = 1'b1;
               state_nxt = IDLE;
            end else if ((beat_cnt == 3'd3) && !tip_ok) begin
               state_nxt = DROP;
            end
         end
         DROP: if (hs && s_axis_arp_last) begin
            drop_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state               <= IDLE;
         beat_cnt            <= 3'd0;
         local_ip            <= P_SRC_IP_ADDR;
         s_axis_arp_ready    <= 1'b0;
         sh_mac              <= '0;
         sh_ip               <= '0;
         is_request          <= 1'b0;
         o_recv_target_mac   <= '0;
         o_recv_target_ip    <= '0;
         o_recv_target_valid <= 1'b0;
         o_arp_reply         <= 1'b0;
      end else begin
         state            <= state_nxt;
         s_axis_arp_ready <= 1'b1;
         if (i_src_ip_valid) local_ip <= i_dymanic_src_ip;

         if (hs) begin
            if (s_axis_arp_last)        beat_cnt <= 3'd0;
            else if (beat_cnt != 3'd4)  beat_cnt <= beat_cnt + 3'd1;
         end

         if (hs && state == IDLE) is_request <= (s_axis_arp_data[15:0] == 16'd1);
         if (hs && state == RECV) begin
            if (beat_cnt == 3'd1) begin
               sh_mac       <= s_axis_arp_data[63:16];
               sh_ip[31:16] <= s_axis_arp_data[15:0];
            end
            if (beat_cnt == 3'd2) sh_ip[15:0] <= s_axis_arp_data[63:48];
         end

         o_recv_target_valid <= accept;
         o_arp_reply         <= accept & is_request;
         if (accept) begin
            o_recv_target_mac <= sh_mac;
            o_recv_target_ip  <= sh_ip;
         end
      end
   end

`ifdef ARP_RX_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_rx_ok_cnt   <= '0;
         o_rx_drop_cnt <= '0;
      end else begin
         if (accept)    o_rx_ok_cnt   <= o_rx_ok_cnt + 16'd1;
         if (drop_done) o_rx_drop_cnt <= o_rx_drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arp_rx.sv
module tb_arp_rx;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [31:0] i_dymanic_src_ip = '0;
   logic        i_src_ip_valid = 1'b0;
   logic [63:0] s_axis_arp_data = '0;
   logic [79:0] s_axis_arp_user = '0;
   logic [7:0]  s_axis_arp_keep = 8'hFF;
   logic        s_axis_arp_last = 1'b0;
   logic        s_axis_arp_valid = 1'b0;
   logic        s_axis_arp_ready;
   logic [47:0] o_recv_target_mac;
   logic [31:0] o_recv_target_ip;
   logic        o_recv_target_valid;
   logic        o_arp_reply;
   logic [47:0] o_local_mac;
`ifdef ARP_RX_STATS_EN
   logic [15:0] o_rx_ok_cnt;
   logic [15:0] o_rx_drop_cnt;
`endif

   arp_rx dut (
      .i_clk               (i_clk),
      .i_rst               (i_rst),
      .i_dymanic_src_ip    (i_dymanic_src_ip),
      .i_src_ip_valid      (i_src_ip_valid),
      .s_axis_arp_data     (s_axis_arp_data),
      .s_axis_arp_user     (s_axis_arp_user),
      .s_axis_arp_keep     (s_axis_arp_keep),
      .s_axis_arp_last     (s_axis_arp_last),
      .s_axis_arp_valid    (s_axis_arp_valid),
      .s_axis_arp_ready    (s_axis_arp_ready),
      .o_recv_target_mac   (o_recv_target_mac),
      .o_recv_target_ip    (o_recv_target_ip),
      .o_recv_target_valid (o_recv_target_valid),
      .o_arp_reply         (o_arp_reply),
`ifdef ARP_RX_STATS_EN
      .o_rx_ok_cnt         (o_rx_ok_cnt),
      .o_rx_drop_cnt       (o_rx_drop_cnt),
`endif
      .o_local_mac         (o_local_mac)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [47:0] mac;
      logic [31:0] ip;
      logic        reply;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model of the visible fields and counters.
   logic [47:0] model_mac = '0;
   logic [31:0] model_ip  = '0;
   int          ok_cnt    = 0;
   int          drop_cnt  = 0;

   localparam logic [47:0] MAC_A = 48'h0A_0B_0C_0D_0E_0F;
   localparam logic [47:0] MAC_B = 48'h11_22_33_44_55_66;
   localparam logic [31:0] IP_A  = 32'hC0A86464;  // 192.168.100.100
   localparam logic [31:0] IP_B  = 32'hC0A86465;
   localparam logic [31:0] IP_US = 32'hC0A86463;  // 192.168.100.99

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every pulse is compared with the oldest expectation.
   always @(negedge i_clk) begin
      if (i_rst) begin
         if (o_recv_target_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'(o_recv_target_valid), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("target_mac", 64'(o_recv_target_mac), 64'(e.mac));
               check("target_ip", 64'(o_recv_target_ip), 64'(e.ip));
               check("arp_reply", 64'(o_arp_reply), 64'(e.reply));
               check("latency", 64'(cyc), 64'(e.cyc));
            end
         end else if (o_arp_reply) begin
            check("reply_without_valid", 64'(o_arp_reply), 64'd0);
         end
      end
   end

   task automatic do_reset_checks();
      check("rst_ready", 64'(s_axis_arp_ready), 64'd0);
      check("rst_mac", 64'(o_recv_target_mac), 64'd0);
      check("rst_ip", 64'(o_recv_target_ip), 64'd0);
      check("rst_valid", 64'(o_recv_target_valid), 64'd0);
      check("rst_reply", 64'(o_arp_reply), 64'd0);
      model_mac = '0;
      model_ip  = '0;
      ok_cnt    = 0;
      drop_cnt  = 0;
   endtask

   // Send one packet of nbeats beats. abort_at >= 0 asserts reset instead of
   // presenting that beat. ld loads ld_ip as local IP during the b3 beat.
   task automatic send_pkt(input logic [15:0] oper, input logic [47:0] smac,
                           input logic [31:0] sip, input logic [31:0] tip,
                           input logic [15:0] etype, input int nbeats,
                           input bit exp_ok, input int abort_at,
                           input bit ld, input logic [31:0] ld_ip);
      logic [63:0] b [4];
      b[0] = {16'h0001, 16'h0800, 8'd6, 8'd4, oper};
      b[1] = {smac, sip[31:16]};
      b[2] = {sip[15:0], 48'hFFFF_FFFF_FFFF};
      b[3] = {tip, 32'd0};
      for (int i = 0; i < nbeats; i++) begin
         if (i == abort_at) begin
            s_axis_arp_valid = 1'b0;
            i_rst = 1'b0;
            #1;
            do_reset_checks();
            @(posedge i_clk); #1;
            i_rst = 1'b1;
            @(posedge i_clk); #1;
            check("ready_after_rst", 64'(s_axis_arp_ready), 64'd1);
            return;
         end
         s_axis_arp_data  = (i < 4) ? b[i] : 64'hDEAD_BEEF_0000_0000 + 64'(i);
         s_axis_arp_user  = {16'd28, smac, etype};
         s_axis_arp_last  = (i == nbeats - 1);
         s_axis_arp_valid = 1'b1;
         if (ld && i == 3) begin
            i_src_ip_valid   = 1'b1;
            i_dymanic_src_ip = ld_ip;
         end
         @(posedge i_clk); #1;
         i_src_ip_valid = 1'b0;
      end
      s_axis_arp_valid = 1'b0;
      s_axis_arp_last  = 1'b0;
      if (exp_ok) begin
         exp_q.push_back('{mac: smac, ip: sip, reply: (oper == 16'd1), cyc: cyc});
         model_mac = smac;
         model_ip  = sip;
         ok_cnt++;
      end else begin
         drop_cnt++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic check_fields(input string name);
      check({name, "_mac"}, 64'(o_recv_target_mac), 64'(model_mac));
      check({name, "_ip"}, 64'(o_recv_target_ip), 64'(model_ip));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state.
      #2;
      do_reset_checks();
      check("local_mac", 64'(o_local_mac), 64'h0102_0304_0506);
      idle(2);
      i_rst = 1'b1;
      idle(1);
      check("ready_out_of_rst", 64'(s_axis_arp_ready), 64'd1);

      // Request to us, 6 beats (padding beats included).
      send_pkt(16'd1, MAC_A, IP_A, IP_US, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      idle(3);
      check_fields("after_req");

      // Reply to us: fields update, no reply pulse.
      send_pkt(16'd2, MAC_B, IP_B, IP_US, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      idle(3);
      check_fields("after_rep");

      // Request to another host: dropped, fields unchanged.
      send_pkt(16'd1, MAC_A, IP_A, 32'hC0A86407, 16'h0806, 6, 1'b0, -1, 1'b0, '0);
      idle(3);
      check_fields("after_other_ip");

      // Wrong ethertype, then a valid request back-to-back.
      send_pkt(16'd1, MAC_B, IP_B, IP_US, 16'h0800, 6, 1'b0, -1, 1'b0, '0);
      send_pkt(16'd1, MAC_A, IP_A, IP_US, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      // Last on b2, then a valid reply back-to-back.
      send_pkt(16'd1, MAC_B, IP_B, IP_US, 16'h0806, 3, 1'b0, -1, 1'b0, '0);
      send_pkt(16'd2, MAC_B, IP_B, IP_US, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      // Last on b0, bad oper 3, then a packet ending exactly on b3.
      send_pkt(16'd1, MAC_A, IP_A, IP_US, 16'h0806, 1, 1'b0, -1, 1'b0, '0);
      send_pkt(16'd3, MAC_A, IP_A, IP_US, 16'h0806, 5, 1'b0, -1, 1'b0, '0);
      send_pkt(16'd1, MAC_A, 32'hC0A8640A, IP_US, 16'h0806, 4, 1'b1, -1, 1'b0, '0);
      idle(3);
      check_fields("after_b2b");

      // Dynamic local IP: load 10.0.0.1, then request it.
      i_src_ip_valid   = 1'b1;
      i_dymanic_src_ip = 32'h0A000001;
      idle(1);
      i_src_ip_valid = 1'b0;
      send_pkt(16'd1, MAC_B, 32'h0A000005, 32'h0A000001, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      // A load coinciding with b3 is not yet visible to that packet.
      send_pkt(16'd1, MAC_A, 32'h0A000006, 32'h0A000001, 16'h0806, 6, 1'b1, -1, 1'b1, 32'h0A000002);
      send_pkt(16'd1, MAC_B, 32'h0A000007, 32'h0A000001, 16'h0806, 6, 1'b0, -1, 1'b0, '0);
      send_pkt(16'd1, MAC_A, 32'h0A000008, 32'h0A000002, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      idle(3);
      check_fields("after_dyn_ip");
`ifdef ARP_RX_STATS_EN
      check("ok_cnt", 64'(o_rx_ok_cnt), 64'(ok_cnt));
      check("drop_cnt", 64'(o_rx_drop_cnt), 64'(drop_cnt));
`endif

      // Reset at b2; the reset also restores the local IP.
      send_pkt(16'd1, MAC_A, IP_A, IP_US, 16'h0806, 6, 1'b0, 2, 1'b0, '0);
      idle(3);
      check_fields("after_abort");
      send_pkt(16'd1, MAC_A, IP_A, IP_US, 16'h0806, 6, 1'b1, -1, 1'b0, '0);
      idle(4);
      check_fields("final");
      check("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef ARP_RX_STATS_EN
      check("ok_cnt_final", 64'(o_rx_ok_cnt), 64'(ok_cnt));
      check("drop_cnt_final", 64'(o_rx_drop_cnt), 64'(drop_cnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
